// File: rtl/gate_sweep_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl_pkg
// Shared definitions for the gate-network sweep controller: sequencer state
// encoding, the default golden truth table for the reference network
// d = (a&b)|(b&c), and the settle-timer width helper.
// -----------------------------------------------------------------------------
package gate_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_REPORT = 3'd3,
        ST_FIN    = 3'd4
    } sweep_state_t;

    // Bit v is the expected network output for input vector v.
    localparam logic [7:0] DEFAULT_TRUTH = 8'hC8;

    // clog2(settle+1), kept at least 1 bit so a zero settle still elaborates.
    function automatic int unsigned timer_width(input int unsigned settle);
        return (settle == 0) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl_if
// Mismatch-record stream (valid/ready) between the sweep controller and the
// consumer of error records.
//   err_valid : record available (master -> slave)
//   err_ready : consumer accepts the record (slave -> master)
//   err_vec   : input vector that mismatched
//   err_got   : sampled network output for err_vec
// -----------------------------------------------------------------------------
interface gate_sweep_ctrl_if #(
    parameter int unsigned N_IN = 3
);
    logic            err_valid;
    logic            err_ready;
    logic [N_IN-1:0] err_vec;
    logic            err_got;

    modport master (
        output err_valid,
        output err_vec,
        output err_got,
        input  err_ready
    );

    modport slave (
        input  err_valid,
        input  err_vec,
        input  err_got,
        output err_ready
    );
endinterface

// File: rtl/gate_sweep_ctrl_timer.sv
// -----------------------------------------------------------------------------
// gate_settle_timer
// Loadable down-counter that measures the settle interval after a new vector
// is driven into the gate network.
//   clk, rst : clock and asynchronous active-high reset
//   load     : load counter with value (takes priority over counting)
//   value    : reload value (settle cycles minus one)
//   zero     : counter has reached zero
// The counter decrements freely whenever it is non-zero and not loading.
// -----------------------------------------------------------------------------
module gate_settle_timer
    import gate_sweep_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    localparam int unsigned W     = timer_width(SETTLE)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
// Exhaustive sweep sequencer for a small combinational gate network. On start
// it drives every input vector 0..2^N_IN-1, waits SETTLE cycles per vector,
// compares the network output with TRUTH, streams each mismatch out over the
// err interface and finally reports pass/fail.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : begin a sweep (sampled only in IDLE)
//   busy      : sweep in progress (decoded from state)
//   done      : one-cycle completion pulse (decoded from state)
//   pass      : result of the last sweep
//   dut_in    : registered vector driven into the network
//   dut_out   : network output, combinational from dut_in
//   err       : mismatch record stream (master side)
//   err_count : mismatches in the current/last sweep
// -----------------------------------------------------------------------------
module gate_sweep_ctrl
    import gate_sweep_ctrl_pkg::*;
#(
    parameter int unsigned                N_IN   = 3,
    parameter int unsigned                SETTLE = 2,
    parameter logic [(1 << N_IN)-1:0]     TRUTH  = DEFAULT_TRUTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    gate_sweep_ctrl_if.master err,
    output logic [N_IN:0]   err_count
);

    localparam int unsigned     TW          = timer_width(SETTLE);
    localparam logic [TW-1:0]   SETTLE_LOAD = (SETTLE == 0) ? '0 : TW'(SETTLE - 1);
    // State entered after a vector is (re)driven: skip SETTLE entirely if zero.
    localparam sweep_state_t    WAIT_ST     = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;

    sweep_state_t state;

    logic at_last;
    logic mismatch;
    logic handshake;
    logic advance;
    logic timer_load;
    logic timer_zero;

    assign at_last   = (dut_in == '1);
    assign mismatch  = (dut_out != TRUTH[dut_in]);
    assign handshake = err.err_valid && err.err_ready;

    // A vector is finished when it matched in CHECK or its report was accepted.
    always_comb begin
        advance    = 1'b0;
        timer_load = 1'b0;
        if ((state == ST_CHECK && !mismatch) || (state == ST_REPORT && handshake)) begin
            advance = 1'b1;
        end
        if (SETTLE != 0) begin
            timer_load = (state == ST_IDLE && start) || (advance && !at_last);
        end
    end

    gate_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .value (SETTLE_LOAD),
        .zero  (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            pass          <= 1'b0;
            dut_in        <= '0;
            err.err_valid <= 1'b0;
            err.err_vec   <= '0;
            err.err_got   <= 1'b0;
            err_count     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dut_in    <= '0;
                        err_count <= '0;
                        pass      <= 1'b0;
                        state     <= WAIT_ST;
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err.err_vec   <= dut_in;
                        err.err_got   <= dut_out;
                        err.err_valid <= 1'b1;
                        err_count     <= err_count + 1'b1;
                        state         <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (handshake) begin
                        err.err_valid <= 1'b0;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Shared advance path for CHECK matches and accepted reports.
            // pass is resolved on entry to FIN (err_count is already final
            // there) so it is valid while done is high.
            if (advance) begin
                if (at_last) begin
                    pass  <= (err_count == '0);
                    state <= ST_FIN;
                end else begin
                    dut_in <= dut_in + 1'b1;
                    state  <= WAIT_ST;
                end
            end
        end
    end

    assign busy = (state == ST_SETTLE) || (state == ST_CHECK) || (state == ST_REPORT);
    assign done = (state == ST_FIN);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
`timescale 1ns/1ps
module tb_gate_sweep_ctrl;

    localparam int unsigned NV = 8;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic sel;
    logic err_ready;
    int unsigned fmode;
    logic [7:0]  fmask;

    always #5 clk = ~clk;

    // Reference network: d = (a&b)|(b&c), a=v[2], b=v[1], c=v[0].
    function automatic logic gold(input logic [2:0] v);
        return (v[2] & v[1]) | (v[1] & v[0]);
    endfunction

    // Network under check: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 flip mask.
    function automatic logic net(input logic [2:0] v, input int unsigned m, input logic [7:0] mask);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            default: return gold(v) ^ mask[v];
        endcase
    endfunction

    // Instance A: SETTLE=2, instance B: SETTLE=0
    logic start_a, busy_a, done_a, pass_a, dout_a;
    logic [2:0] din_a;
    logic [3:0] cnt_a;
    logic start_b, busy_b, done_b, pass_b, dout_b;
    logic [2:0] din_b;
    logic [3:0] cnt_b;

    gate_sweep_ctrl_if #(.N_IN(3)) eif_a ();
    gate_sweep_ctrl_if #(.N_IN(3)) eif_b ();

    assign start_a = start && !sel;
    assign start_b = start && sel;
    assign eif_a.err_ready = err_ready;
    assign eif_b.err_ready = err_ready;
    assign dout_a = net(din_a, fmode, fmask);
    assign dout_b = net(din_b, fmode, fmask);

    gate_sweep_ctrl #(.N_IN(3), .SETTLE(2), .TRUTH(8'hC8)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .dut_in(din_a), .dut_out(dout_a), .err(eif_a), .err_count(cnt_a)
    );

    gate_sweep_ctrl #(.N_IN(3), .SETTLE(0), .TRUTH(8'hC8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .dut_in(din_b), .dut_out(dout_b), .err(eif_b), .err_count(cnt_b)
    );

    // Monitor view of the selected instance
    logic m_busy, m_done, m_pass, m_valid, m_got;
    logic [2:0] m_in, m_vec;
    logic [3:0] m_cnt;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_pass  = sel ? pass_b : pass_a;
    assign m_valid = sel ? eif_b.err_valid : eif_a.err_valid;
    assign m_got   = sel ? eif_b.err_got : eif_a.err_got;
    assign m_in    = sel ? din_b : din_a;
    assign m_vec   = sel ? eif_b.err_vec : eif_a.err_vec;
    assign m_cnt   = sel ? cnt_b : cnt_a;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // One full sweep against the reference model. stall_fixed<0 picks a
    // random consumer stall per record; poke_start throws ignored starts in.
    task automatic run_sweep(input logic s, input int unsigned mode, input logic [7:0] mask,
                             input int stall_fixed, input bit poke_start);
        logic [2:0]  expq[$];
        logic [2:0]  cur_vec;
        logic [2:0]  prev_in;
        int unsigned settle, nexp, exp_busy, busy_cnt, stall_tgt, stall_cnt;
        bit          in_rec, seen_done;

        sel = s;
        fmode = mode;
        fmask = mask;
        settle = s ? 0 : 2;
        for (int v = 0; v < NV; v++)
            if (net(3'(v), mode, mask) != gold(3'(v))) expq.push_back(3'(v));
        nexp      = expq.size();
        exp_busy  = NV * (settle + 1);
        busy_cnt  = 0;
        stall_tgt = 0;
        stall_cnt = 0;
        in_rec    = 0;
        seen_done = 0;
        cur_vec   = '0;
        prev_in   = '0;

        @(negedge clk);
        start = 1'b1;
        err_ready = 1'b0;
        for (int cyc = 0; cyc < 2000 && !seen_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (m_done) begin
                seen_done = 1;
                check("busy_in_fin", m_busy, 0);
                check("busy_cycles", busy_cnt, exp_busy);
                check("records_left", expq.size(), 0);
                check("pass", m_pass, (nexp == 0));
                check("err_count", m_cnt, nexp);
                check("last_vec", m_in, 7);
                check("valid_in_fin", m_valid, 0);
                start = poke_start;
            end else begin
                check("busy", m_busy, 1);
                if (busy_cnt == 0) check("first_vec", m_in, 0);
                else if (m_in != prev_in) check("vec_step", m_in, prev_in + 1);
                if (nexp == 0) check("schedule", m_in, busy_cnt / (settle + 1));
                if (m_valid) begin
                    if (!in_rec) begin
                        in_rec    = 1;
                        stall_cnt = 0;
                        stall_tgt = (stall_fixed >= 0) ? unsigned'(stall_fixed) : $urandom_range(0, 4);
                        exp_busy += stall_tgt + 1;
                        check("record_expected", (expq.size() != 0), 1);
                        cur_vec = (expq.size() != 0) ? expq[0] : 3'd0;
                        check("rec_got", m_got, net(cur_vec, mode, mask));
                    end
                    check("rec_vec", m_vec, cur_vec);
                    check("in_hold", m_in, cur_vec);
                    if (stall_cnt < stall_tgt) begin
                        err_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        err_ready = 1'b1;
                        in_rec = 0;
                        if (expq.size() != 0) void'(expq.pop_front());
                    end
                end else begin
                    err_ready = 1'($urandom_range(0, 1));
                end
                if (poke_start) start = ($urandom_range(0, 2) == 0);
                busy_cnt++;
                prev_in = m_in;
            end
        end
        check("done_seen", seen_done, 1);
        @(negedge clk);
        start = 1'b0;
        err_ready = 1'b0;
        check("done_width", m_done, 0);
        check("pass_hold", m_pass, (nexp == 0));
        repeat (3) @(negedge clk);
        check("idle_after", {m_busy, m_done}, 2'b00);
    endtask

    task automatic reset_mid();
        int unsigned n_done;
        bit hit;
        sel = 1'b0;
        fmode = 0;
        fmask = '0;
        hit = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (busy_a && din_a == 3'd5) hit = 1;
            else @(negedge clk);
        end
        check("reach_vec5", din_a, 5);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_dut_in", din_a, 0);
        check("rst_err_cnt", cnt_a, 0);
        check("rst_err", {eif_a.err_valid, eif_a.err_vec, eif_a.err_got}, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_a || busy_a) n_done++;
        end
        check("no_done_after_rst", n_done, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        sel = 1'b0;
        err_ready = 1'b0;
        fmode = 0;
        fmask = '0;
        repeat (2) @(negedge clk);
        check("init_busy", {busy_a, busy_b}, 0);
        check("init_done", {done_a, done_b}, 0);
        check("init_pass", {pass_a, pass_b}, 0);
        check("init_dut_in", {din_a, din_b}, 0);
        check("init_err_cnt", {cnt_a, cnt_b}, 0);
        check("init_err", {eif_a.err_valid, eif_a.err_vec, eif_a.err_got, eif_b.err_valid}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_sweep(1'b0, 0, 8'h00, -1, 1'b0);   // correct network, SETTLE=2
        run_sweep(1'b0, 1, 8'h00, -1, 1'b0);   // stuck-at-0: records 3,6,7
        run_sweep(1'b0, 3, 8'h08, 5, 1'b0);    // fault at 3, consumer stalls 5
        run_sweep(1'b1, 0, 8'h00, -1, 1'b0);   // correct network, SETTLE=0
        run_sweep(1'b1, 2, 8'h00, -1, 1'b0);   // stuck-at-1, SETTLE=0
        reset_mid();
        run_sweep(1'b0, 1, 8'h00, -1, 1'b0);   // fresh sweep after abort
        run_sweep(1'b0, 0, 8'h00, -1, 1'b1);   // stray starts ignored
        run_sweep(1'b1, 3, 8'h81, 2, 1'b1);    // both boundary vectors fault
        for (int k = 0; k < 6; k++)
            run_sweep(1'($urandom_range(0, 1)), 3, 8'($urandom), -1, 1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
